data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, 64, number of 32-bit words in the data memory (power of two).
REQ-002 Parameter WAIT_CYCLES, 2, wait states between request acceptance and array access (0..15).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  memory-stage request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 load_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 addr  input  32  byte address.
REQ-011 wdata  input  32  store data, right-aligned for sub-word stores.
REQ-012 rdata  output  32  load result; feeds the memory/ALU select mux in writeback.
REQ-013 resp_valid  output  1  one-cycle pulse: the access is complete.
REQ-014 resp_load  output  1  qualifies resp_valid; 1 = rdata is valid load data (mux select source).
REQ-015 err  output  1  qualifies resp_valid; misaligned or reserved-size request.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept on req_valid && req_ready; latch we, size, load_unsigned, addr, wdata in the same edge.
REQ-018 IDLE -> WAIT on accept, with the wait counter loaded to WAIT_CYCLES-1; IDLE -> RESP directly when WAIT_CYCLES = 0.
REQ-019 WAIT: counter decrements each cycle; at 0, the array access is performed and the FSM moves to RESP.
REQ-020 RESP: resp_valid = 1 for exactly one cycle, then IDLE; latency from accept edge to resp_valid = WAIT_CYCLES+1 cycles.
REQ-021 No new request is accepted in WAIT or RESP; the next accept is possible in the cycle after RESP.
REQ-022 Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored (wrap-around modulo DEPTH words).
REQ-023 Misaligned = (size=01 && addr[0]) || (size=10 && addr[1:0]!=0); misaligned or size=11 -> err=1, no store, rdata=0.
REQ-024 Store: only the addressed byte lanes are written (byte lane addr[1:0], half lane addr[1]); other lanes unchanged.
REQ-025 Load: select lane, then sign- or zero-extend per load_unsigned; word loads are unmodified.
REQ-026 rdata, resp_load, err hold their values until the next RESP; resp_load = ~we of the completed request.

Reset
REQ-027 On rst: state = IDLE, counter = 0, resp_valid = 0, resp_load = 0, err = 0, rdata = 0; req_ready = 1 once rst deasserts.
REQ-028 Reset mid-operation aborts the transaction: a store still in WAIT is not performed; no response is produced.
REQ-029 Memory array contents are not reset.

Structure
REQ-030 Shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-031 One sub-module, data_mem_array: DEPTH x 32, synchronous write with 4-bit byte-enable, combinational read.

Verification
REQ-032 Reset, WAIT_CYCLES=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, resp_load=1.
REQ-033 Store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; load unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-034 Load half @0x11 -> err=1, rdata=0, no state change; store word @0x22 -> err=1, @0x20 unchanged.
REQ-035 DEPTH=64: store 0x12345678 @0x100 -> load word @0x0 returns 0x12345678 (wrap).
REQ-036 Assert rst one cycle after accepting a store of 0xAAAAAAAA @0x40 -> no resp_valid; subsequent load @0x40 returns the prior value.
REQ-037 WAIT_CYCLES=0 with req_valid held high -> accepts every second cycle, resp_valid one cycle after each accept, req_ready low during RESP.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: access size codes,
// controller state encoding and the lane steering helpers used on the
// store and load paths.
package data_mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // A request is rejected when it is not naturally aligned or uses the reserved size.
   function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte-lane enables for a store of the given size at the given byte offset.
   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data across all lanes; the enables pick the live lanes.
   function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                                input logic [1:0]  lo,
                                                input logic        zext,
                                                input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = zext ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = zext ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 data array: synchronous byte-enabled write, combinational read.
// Contents are deliberately left out of reset.
module data_mem_array #(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Write only the enabled byte lanes; untouched lanes keep their contents.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage data memory controller: accepts one load/store at a time,
// waits WAIT_CYCLES, performs the array access and returns a one-cycle
// response with load data or an error flag.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   WAIT  | request latched, wait counter running; access on terminal count
//   RESP  | access done; response registered on the way back to IDLE
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        resp_valid,
   output logic        resp_load,
   output logic        err
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t        state;
   logic [3:0]    cnt;
   logic          we_q;
   logic          lu_q;
   logic [1:0]    size_q;
   logic [AW+1:0] addr_q;
   logic [31:0]   wdata_q;

   logic          bad;
   logic          access;
   logic          mem_wr;
   logic [31:0]   mem_rd;

   // Address bits above the array are ignored so accesses wrap modulo DEPTH.
   logic unused_addr;
   assign unused_addr = &{1'b0, addr[31:AW+2]};

   assign bad = bad_access(size_q, addr_q[1:0]);

   // With no wait states the access happens on the edge leaving RESP; otherwise
   // on the terminal count of the wait counter.
   always_comb begin
      if (WAIT_CYCLES == 0) begin
         access = (state == RESP);
      end else begin
         access = (state == WAIT) && (cnt == 4'd0);
      end
   end

   // Rejected requests never write; reset kills a write that is still pending.
   assign mem_wr = access && we_q && !bad && !rst;

   data_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .wr_en (mem_wr),
      .be    (lane_enables(size_q, addr_q[1:0])),
      .idx   (addr_q[AW+1:2]),
      .wdata (store_align(size_q, wdata_q)),
      .rdata (mem_rd)
   );

   // Request/response FSM with registered handshake and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_load  <= 1'b0;
         err        <= 1'b0;
         rdata      <= 32'h0;
         we_q       <= 1'b0;
         lu_q       <= 1'b0;
         size_q     <= SZ_BYTE;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  we_q      <= we;
                  lu_q      <= load_unsigned;
                  size_q    <= size;
                  addr_q    <= addr[AW+1:0];
                  wdata_q   <= wdata;
                  req_ready <= 1'b0;
                  if (WAIT_CYCLES == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b1;
               resp_load  <= ~we_q;
               err        <= bad;
               // Loads only read, so the array still holds the word seen at access time.
               rdata      <= (bad || we_q) ? 32'h0
                                           : load_extract(size_q, addr_q[1:0], lu_q, mem_rd);
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (2 wait states and 0 wait states)
// checked every cycle against a transaction-level model, plus directed
// transactions with hand-computed expectations.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_t  [2];
   logic        req_ready_t  [2];
   logic        we_t         [2];
   logic [1:0]  size_t       [2];
   logic        lu_t         [2];
   logic [31:0] addr_t       [2];
   logic [31:0] wdata_t      [2];
   logic [31:0] rdata_t      [2];
   logic        resp_valid_t [2];
   logic        resp_load_t  [2];
   logic        err_t        [2];

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid_t[0]), .req_ready(req_ready_t[0]),
      .we(we_t[0]), .size(size_t[0]), .load_unsigned(lu_t[0]), .addr(addr_t[0]),
      .wdata(wdata_t[0]), .rdata(rdata_t[0]), .resp_valid(resp_valid_t[0]),
      .resp_load(resp_load_t[0]), .err(err_t[0]));

   data_mem_ctrl #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid_t[1]), .req_ready(req_ready_t[1]),
      .we(we_t[1]), .size(size_t[1]), .load_unsigned(lu_t[1]), .addr(addr_t[1]),
      .wdata(wdata_t[1]), .rdata(rdata_t[1]), .resp_valid(resp_valid_t[1]),
      .resp_load(resp_load_t[1]), .err(err_t[1]));

   function automatic int wc(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", nm, i, $time, act, exp);
      end
   endtask

   // Reference behaviour of one access as byte-level arithmetic.
   function automatic void ref_access(input logic [31:0] old, input logic w, input logic [1:0] sz,
                                      input logic lu, input logic [31:0] a, input logic [31:0] d,
                                      output logic [31:0] nw, output logic [31:0] rd, output logic er);
      int off, nbytes;
      logic [7:0] by [4];
      longint v;
      off    = int'(a % 4);
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      er     = (sz == 2'd3) || (off % nbytes != 0);
      nw     = old;
      rd     = 32'h0;
      if (er) return;
      for (int j = 0; j < 4; j++) by[j] = old[8*j +: 8];
      if (w) begin
         for (int j = 0; j < nbytes; j++) by[off+j] = d[8*j +: 8];
         nw = {by[3], by[2], by[1], by[0]};
      end else begin
         v = 0;
         for (int j = nbytes - 1; j >= 0; j--) v = v * 256 + longint'(by[off+j]);
         if (!lu && nbytes < 4 && v >= (longint'(1) << (8*nbytes - 1)))
            v = v - (longint'(1) << (8*nbytes));
         rd = v[31:0];
      end
   endfunction

   // Transaction-level model: one request in flight, response WAIT_CYCLES+1 edges after accept.
   logic [31:0] mmem [2][64];
   int          busy [2];
   int          left [2];
   logic        e_valid [2], e_ready [2], e_load [2], e_err [2];
   logic [31:0] e_rdata [2];
   logic        p_we [2], p_lu [2];
   logic [1:0]  p_size [2];
   logic [31:0] p_addr [2], p_wdata [2];

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy[i] = 0; left[i] = 0;
            e_valid[i] = 0; e_ready[i] = 1; e_load[i] = 0; e_err[i] = 0; e_rdata[i] = 0;
         end else begin
            e_valid[i] = 0;
            if (busy[i] != 0) begin
               left[i]--;
               if (left[i] == 0) begin
                  int idx;
                  logic [31:0] nw, rd;
                  logic er;
                  idx = int'((p_addr[i] >> 2) % 64);
                  ref_access(mmem[i][idx], p_we[i], p_size[i], p_lu[i], p_addr[i], p_wdata[i], nw, rd, er);
                  mmem[i][idx] = nw;
                  busy[i]    = 0;
                  e_valid[i] = 1;
                  e_err[i]   = er;
                  e_load[i]  = !p_we[i];
                  e_rdata[i] = rd;
               end
            end else if (req_valid_t[i]) begin
               p_we[i] = we_t[i]; p_lu[i] = lu_t[i]; p_size[i] = size_t[i];
               p_addr[i] = addr_t[i]; p_wdata[i] = wdata_t[i];
               busy[i] = 1;
               left[i] = wc(i) + 1;
            end
            e_ready[i] = (busy[i] == 0);
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            chk("resp_valid", i, 32'(resp_valid_t[i]), 32'(e_valid[i]));
            chk("req_ready",  i, 32'(req_ready_t[i]),  32'(e_ready[i]));
            chk("rdata",      i, rdata_t[i],           e_rdata[i]);
            chk("err",        i, 32'(err_t[i]),        32'(e_err[i]));
            chk("resp_load",  i, 32'(resp_load_t[i]),  32'(e_load[i]));
         end
      end
   end

   task automatic txn(input int i, input logic w, input logic [1:0] sz, input logic l,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output logic rl, output int lat);
      @(posedge clk); #1;
      req_valid_t[i] = 1'b1; we_t[i] = w; size_t[i] = sz; lu_t[i] = l;
      addr_t[i] = a; wdata_t[i] = d;
      @(posedge clk); #1;
      req_valid_t[i] = 1'b0;
      lat = 0;
      while (resp_valid_t[i] !== 1'b1 && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      if (resp_valid_t[i] !== 1'b1) begin
         checks++; failures++;
         $display("FAIL resp_timeout inst=%0d got=no_response exp=response", i);
      end
      rd = rdata_t[i]; er = err_t[i]; rl = resp_load_t[i];
   endtask

   task automatic rand_fields(input int i);
      we_t[i]    = 1'($urandom_range(0, 1));
      size_t[i]  = 2'($urandom_range(0, 3));
      lu_t[i]    = 1'($urandom_range(0, 1));
      addr_t[i]  = $urandom;
      wdata_t[i] = $urandom;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic er, rl;
      int lat, pulses, lows;

      for (int i = 0; i < 2; i++) begin
         req_valid_t[i] = 0; we_t[i] = 0; size_t[i] = 0; lu_t[i] = 0; addr_t[i] = 0; wdata_t[i] = 0;
      end
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_on = 1;

      chk("reset_ready", 0, 32'(req_ready_t[0]), 32'h1);
      chk("reset_valid", 0, 32'(resp_valid_t[0]), 32'h0);
      chk("reset_rdata", 0, rdata_t[0], 32'h0);
      chk("reset_ready", 1, 32'(req_ready_t[1]), 32'h1);

      // Fill both arrays with a known word pattern.
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 64; k++)
            txn(i, 1'b1, 2'b10, 1'b0, 32'(k * 4), 32'hA500_0000 + 32'(k) * 32'h0001_0203, rd, er, rl, lat);

      txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, rl, lat);
      chk("st_word_lat", 0, 32'(lat), 32'd3);
      chk("st_word_load", 0, 32'(rl), 32'h0);
      chk("st_word_err", 0, 32'(er), 32'h0);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, rl, lat);
      chk("ld_word_lat", 0, 32'(lat), 32'd3);
      chk("ld_word", 0, rd, 32'hDEADBEEF);
      chk("ld_word_load", 0, 32'(rl), 32'h1);

      txn(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, rd, er, rl, lat);
      txn(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, rl, lat);
      chk("ld_byte_signed", 0, rd, 32'hFFFFFF80);
      txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, rl, lat);
      chk("ld_byte_unsigned", 0, rd, 32'h00000080);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, rl, lat);
      chk("ld_word_after_byte", 0, rd, 32'h80ADBEEF);

      txn(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, er, rl, lat);
      chk("misaligned_half_err", 0, 32'(er), 32'h1);
      chk("misaligned_half_rdata", 0, rd, 32'h0);
      txn(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h55555555, rd, er, rl, lat);
      chk("misaligned_word_err", 0, 32'(er), 32'h1);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, rl, lat);
      chk("no_store_on_err", 0, rd, 32'hA5081018);
      txn(0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, rd, er, rl, lat);
      chk("reserved_size_err", 0, 32'(er), 32'h1);

      txn(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, rd, er, rl, lat);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, rl, lat);
      chk("wrap_word", 0, rd, 32'h12345678);
      txn(0, 1'b0, 2'b01, 1'b0, 32'hFFFF_FF02, 32'h0, rd, er, rl, lat);
      chk("wrap_half_signed", 0, rd, 32'h00001234);

      // Abort a store with reset one cycle after it is accepted.
      @(posedge clk); #1;
      req_valid_t[0] = 1; we_t[0] = 1; size_t[0] = 2'b10; lu_t[0] = 0;
      addr_t[0] = 32'h40; wdata_t[0] = 32'hAAAAAAAA;
      @(posedge clk); #1;
      req_valid_t[0] = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (resp_valid_t[0] === 1'b1) pulses++;
      end
      chk("abort_no_resp", 0, 32'(pulses), 32'h0);
      txn(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, rl, lat);
      chk("abort_no_store", 0, rd, 32'hA5102030);

      for (int n = 0; n < 150; n++) begin
         txn(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, rd, er, rl, lat);
         chk("rand_lat", 0, 32'(lat), 32'd3);
      end

      // Zero wait states with req_valid held high.
      @(posedge clk); #1;
      req_valid_t[1] = 1'b1;
      rand_fields(1);
      pulses = 0; lows = 0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (resp_valid_t[1] === 1'b1) pulses++;
         if (req_ready_t[1] === 1'b0) lows++;
         rand_fields(1);
      end
      req_valid_t[1] = 1'b0;
      chk("held_resp_count", 1, 32'(pulses), 32'd20);
      chk("held_ready_low", 1, 32'(lows), 32'd20);

      for (int n = 0; n < 40; n++) begin
         txn(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, rd, er, rl, lat);
         chk("rand_lat0", 1, 32'(lat), 32'd1);
      end

      repeat (4) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
